// File: rtl/async_fifo.sv
// Gray-pointer FIFO with dual-pointer flag logic on one shared clock.
// Ports: wclk, wrst_n, winc/wdata/wfull (push), rinc/rdata/rempty (pop). Macro: ASYNC_FIFO_SYNC_BYPASS_EN.
module async_fifo #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  output logic             wfull,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty
);

  localparam int DEPTH = 1 << ASIZE;

  logic [DSIZE-1:0] r_mem [DEPTH];

  logic [ASIZE:0] r_wbin;
  logic [ASIZE:0] r_wptr;
  logic [ASIZE:0] r_rbin;
  logic [ASIZE:0] r_rptr;
  logic           r_wfull;
  logic           r_rempty;

  logic           w_wen;
  logic           w_ren;
  logic [ASIZE:0] w_wbinnext;
  logic [ASIZE:0] w_wgraynext;
  logic [ASIZE:0] w_rbinnext;
  logic [ASIZE:0] w_rgraynext;
  logic [ASIZE:0] w_wq2_rptr;
  logic [ASIZE:0] w_rq2_wptr;
  logic [ASIZE:0] w_full_cmp;

  // Nothing is accepted during a reset cycle.
  assign w_wen = winc & ~r_wfull & wrst_n;
  assign w_ren = rinc & ~r_rempty & wrst_n;

  assign w_wbinnext  = r_wbin + (ASIZE+1)'(w_wen);
  assign w_wgraynext = w_wbinnext ^ (w_wbinnext >> 1);
  assign w_rbinnext  = r_rbin + (ASIZE+1)'(w_ren);
  assign w_rgraynext = w_rbinnext ^ (w_rbinnext >> 1);

  always_ff @(posedge wclk) begin
    if (w_wen) begin
      r_mem[r_wbin[ASIZE-1:0]] <= wdata;
    end
  end

  assign rdata = r_mem[r_rbin[ASIZE-1:0]];

`ifdef ASYNC_FIFO_SYNC_BYPASS_EN
  assign w_wq2_rptr = r_rptr;
  assign w_rq2_wptr = r_wptr;
`else
  logic [ASIZE:0] r_wq1_rptr;
  logic [ASIZE:0] r_wq2_rptr;
  logic [ASIZE:0] r_rq1_wptr;
  logic [ASIZE:0] r_rq2_wptr;

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      r_wq1_rptr <= '0;
      r_wq2_rptr <= '0;
      r_rq1_wptr <= '0;
      r_rq2_wptr <= '0;
    end else begin
      r_wq1_rptr <= r_rptr;
      r_wq2_rptr <= r_wq1_rptr;
      r_rq1_wptr <= r_wptr;
      r_rq2_wptr <= r_rq1_wptr;
    end
  end

  assign w_wq2_rptr = r_wq2_rptr;
  assign w_rq2_wptr = r_rq2_wptr;
`endif

  // Full when the Gray pointers differ only in their top two bits.
  assign w_full_cmp = {~w_wq2_rptr[ASIZE:ASIZE-1],
                       w_wq2_rptr[ASIZE-2:0]};

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      r_wbin  <= '0;
      r_wptr  <= '0;
      r_wfull <= 1'b0;
    end else begin
      r_wbin  <= w_wbinnext;
      r_wptr  <= w_wgraynext;
      r_wfull <= (w_wgraynext == w_full_cmp);
    end
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      r_rbin   <= '0;
      r_rptr   <= '0;
      r_rempty <= 1'b1;
    end else begin
      r_rbin   <= w_rbinnext;
      r_rptr   <= w_rgraynext;
      r_rempty <= (w_rgraynext == w_rq2_wptr);
    end
  end

  assign wfull  = r_wfull;
  assign rempty = r_rempty;

endmodule

// File: tb/tb_async_fifo.sv
// Scoreboard bench for async_fifo: count-history flag model plus data queue.
// Monitor checks flags every cycle and pops/compares data on each accepted read.
module tb_async_fifo;

  localparam int DSIZE = 8;
  localparam int ASIZE = 4;
  localparam int DEPTH = 1 << ASIZE;
`ifdef ASYNC_FIFO_SYNC_BYPASS_EN
  localparam int DLY = 1;
`else
  localparam int DLY = 3;
`endif

  logic             wclk;
  logic             wrst_n;
  logic             winc;
  logic [DSIZE-1:0] wdata;
  logic             wfull;
  logic             rinc;
  logic [DSIZE-1:0] rdata;
  logic             rempty;

  async_fifo #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
    .wclk  (wclk),
    .wrst_n(wrst_n),
    .winc  (winc),
    .wdata (wdata),
    .wfull (wfull),
    .rinc  (rinc),
    .rdata (rdata),
    .rempty(rempty)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  int errs   = 0;
  int checks = 0;

  // Model: total accepted pushes/pops, with per-edge history of both counts.
  int   wh [0:3];
  int   rh [0:3];
  int   wc = 0;
  int   rc = 0;
  logic m_rempty = 1'b1;
  logic m_wfull  = 1'b0;
  logic chk_en   = 1'b0;
  logic [DSIZE-1:0] exp_q [$];

  initial begin
    for (int k = 0; k < 4; k++) begin
      wh[k] = 0;
      rh[k] = 0;
    end
  end

  always @(posedge wclk) begin
    bit push;
    bit pop;
    if (!wrst_n) begin
      wc = 0;
      rc = 0;
      for (int k = 0; k < 4; k++) begin
        wh[k] = 0;
        rh[k] = 0;
      end
      m_rempty = 1'b1;
      m_wfull  = 1'b0;
      exp_q.delete();
      chk_en = 1'b1;
    end else begin
      push = winc && !m_wfull;
      pop  = rinc && !m_rempty;
      if (push) exp_q.push_back(wdata);
      wc += int'(push);
      rc += int'(pop);
      for (int k = 3; k > 0; k--) begin
        wh[k] = wh[k-1];
        rh[k] = rh[k-1];
      end
      wh[0] = wc;
      rh[0] = rc;
      m_rempty = (rc == wh[DLY]);
      m_wfull  = ((wc - rh[DLY]) == DEPTH);
    end
  end

  // Monitor: flags every cycle; data on every read the DUT will accept.
  always @(negedge wclk) begin
    if (chk_en) begin
      checks++;
      if (rempty !== m_rempty) begin
        errs++;
        $display("FAIL rempty t=%0t got=%b exp=%b", $time, rempty, m_rempty);
      end
      checks++;
      if (wfull !== m_wfull) begin
        errs++;
        $display("FAIL wfull t=%0t got=%b exp=%b", $time, wfull, m_wfull);
      end
      if (wrst_n && rinc && rempty === 1'b0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errs++;
          $display("FAIL rdata_underflow t=%0t got=%h exp=none", $time, rdata);
        end else begin
          logic [DSIZE-1:0] e;
          e = exp_q.pop_front();
          if (rdata !== e) begin
            errs++;
            $display("FAIL rdata t=%0t got=%h exp=%h", $time, rdata, e);
          end
        end
      end
    end
  end

  task automatic cyc(input logic w, input logic [DSIZE-1:0] d,
                     input logic r);
    winc  = w;
    wdata = d;
    rinc  = r;
    @(posedge wclk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (wc != rc && n < 200) begin
      cyc(1'b0, '0, 1'b1);
      n++;
    end
    checks++;
    if (wc != rc) begin
      errs++;
      $display("FAIL drain_timeout got=%0d exp=0", wc - rc);
    end
    idle(4);
  endtask

  initial begin
    int nxt;
    int n;
    int occ;
    logic w;
    logic r;
    wrst_n = 1'b0;
    winc   = 1'b0;
    rinc   = 1'b0;
    wdata  = '0;
    @(posedge wclk);
    #1;
    cyc(1'b0, '0, 1'b0);
    wrst_n = 1'b1;

    // Popping an empty FIFO.
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1);

    // Fill 1..16, extra push ignored.
    for (int i = 1; i <= 16; i++) cyc(1'b1, DSIZE'(i), 1'b0);
    cyc(1'b1, 8'hAA, 1'b0);
    idle(4);

    // Drain with one extra pop.
    for (int i = 0; i < 17; i++) cyc(1'b0, '0, 1'b1);
    idle(4);

    // Wrap-around, occupancy kept in 1..15.
    nxt = 0;
    n = 0;
    while ((nxt < 40 || wc != rc) && n < 3000) begin
      occ = wc - rc;
      w = (nxt < 40) && (occ < 15) && ($urandom_range(0, 1) == 1);
      r = (occ > 1 || nxt == 40) && ($urandom_range(0, 1) == 1);
      if (w && !m_wfull) begin
        cyc(1'b1, DSIZE'(nxt), r);
        nxt++;
      end else begin
        cyc(1'b0, '0, r);
      end
      n++;
    end
    checks++;
    if (nxt != 40 || wc != rc) begin
      errs++;
      $display("FAIL wrap_timeout got=%0d exp=40", nxt);
    end
    idle(4);

    // Simultaneous push and pop with 5 stored.
    for (int i = 0; i < 5; i++) cyc(1'b1, DSIZE'(50 + i), 1'b0);
    idle(4);
    for (int i = 0; i < 10; i++) cyc(1'b1, DSIZE'(200 + i), 1'b1);
    checks++;
    if (wc - rc != 5) begin
      errs++;
      $display("FAIL simul_occ got=%0d exp=5", wc - rc);
    end
    drain();

    // Reset mid-operation, with requests held during the reset edge.
    for (int i = 0; i < 7; i++) cyc(1'b1, DSIZE'(30 + i), 1'b0);
    idle(4);
    wrst_n = 1'b0;
    cyc(1'b1, 8'h55, 1'b1);
    wrst_n = 1'b1;
    cyc(1'b1, 8'd100, 1'b0);
    cyc(1'b1, 8'd101, 1'b0);
    idle(4);
    drain();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 2) != 0, DSIZE'($urandom),
          $urandom_range(0, 2) == 0);
    end
    for (int i = 0; i < 200; i++) begin
      cyc($urandom_range(0, 2) == 0, DSIZE'($urandom),
          $urandom_range(0, 2) != 0);
    end
    drain();

    checks++;
    if (exp_q.size() != 0) begin
      errs++;
      $display("FAIL leftover got=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
